sm_addsub_pipe: RTL and testbench

Parametrised, two-stage pipelined sign-magnitude adder/subtractor with an internal saturating accumulator and valid/ready handshakes on both sides. Operands are W-bit sign-magnitude values (MSB sign, W-1 magnitude bits). Results are (W+1)-bit sign-magnitude values. The block is the general-width, streaming arithmetic unit of the ALU datapath. It also adds negative-zero normalisation and accumulate modes.

---
 rtl/sm_addsub_pipe.sv | 199 +++++++++++++++++++
 tb/tb_sm_addsub_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_addsub_pipe.sv
// Two-stage pipelined sign-magnitude add/subtract unit with a saturating accumulator.
// Latency: a beat accepted at one rising edge is presented (out_valid=1) after the following edge.
// Backpressure: in_ready = (!out_valid | out_ready) & !rst; both stages freeze while the output stalls.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   input handshake carrying op, a, b
//   op                    00 A+B, 01 A-B, 10 ACC+=A, 11 ACC-=A
//   a, b                  W-bit sign-magnitude operands (MSB = sign)
//   acc_clr               clears the accumulator at the next edge, independent of the handshake
//   out_valid / out_ready output handshake carrying r, ovf, zero
//   r                     (W+1)-bit sign-magnitude result, never -0
//   ovf                   accumulate result saturated
//   zero                  r magnitude is zero
//   acc_q                 registered accumulator value

module sm_addsub_pipe #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         acc_clr,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W:0]   r,
   output logic         ovf,
   output logic         zero,
   output logic [W:0]   acc_q
);

   localparam logic [W-1:0] MAG_MAX = '1;

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   logic advance;
   logic fire;
   logic is_acc;

   // ------------------------------------------------------------------
   // Effective operands and arithmetic
   // ------------------------------------------------------------------
   logic [W:0]   acc_base;
   logic         x_sign;
   logic         y_sign;
   logic [W-1:0] x_mag;
   logic [W-1:0] y_mag;
   logic [W:0]   sum_full;
   logic [W-1:0] res_mag;
   logic         res_sign;
   logic         res_ovf;

   // ------------------------------------------------------------------
   // Pipeline state
   // ------------------------------------------------------------------
   logic         s1_vld_d,  s1_vld_q;
   logic [W-1:0] s1_mag_d,  s1_mag_q;
   logic         s1_sign_d, s1_sign_q;
   logic         s1_ovf_d,  s1_ovf_q;
   logic         out_vld_d, out_vld_q;
   logic [W:0]   r_d,       r_q;
   logic         ovf_d,     ovf_q;
   logic         zero_d,    zero_q;
   logic [W:0]   acc_d;

   assign is_acc = op[1];

   // Operand selection and sign-magnitude add/subtract.
   always_comb begin
      // A clear coinciding with an accumulate op acts on the op's view of
      // the old value, so the clear and the op both take effect.
      acc_base = acc_clr ? '0 : acc_q;

      if (is_acc) begin
         x_mag  = acc_base[W-1:0];
         x_sign = acc_base[W];
         y_mag  = {1'b0, a[W-2:0]};
         y_sign = a[W-1] ^ op[0];
      end else begin
         x_mag  = {1'b0, a[W-2:0]};
         x_sign = a[W-1];
         y_mag  = {1'b0, b[W-2:0]};
         y_sign = b[W-1] ^ op[0];
      end

      // A zero magnitude carries no sign, so -0 behaves exactly like +0
      // when comparing signs below.
      x_sign = x_sign & (|x_mag);
      y_sign = y_sign & (|y_mag);

      sum_full = {1'b0, x_mag} + {1'b0, y_mag};

      res_mag  = '0;
      res_sign = 1'b0;
      res_ovf  = 1'b0;

      if (x_sign == y_sign) begin
         // Only the accumulate path can carry out of W bits: two (W-1)-bit
         // magnitudes sum to at most 2^W-2.
         if (sum_full[W]) begin
            res_mag = MAG_MAX;
            res_ovf = 1'b1;
         end else begin
            res_mag = sum_full[W-1:0];
         end
         res_sign = x_sign;
      end else if (x_mag > y_mag) begin
         res_mag  = x_mag - y_mag;
         res_sign = x_sign;
      end else if (y_mag > x_mag) begin
         res_mag  = y_mag - x_mag;
         res_sign = y_sign;
      end

      // Keep the accumulator free of -0 as well as the output.
      res_sign = res_sign & (|res_mag);
      res_ovf  = res_ovf & is_acc;
   end

   // Flow control and next-state for both stages and the accumulator.
   always_comb begin
      advance  = !out_vld_q || out_ready;
      in_ready = advance && !rst;
      fire     = in_valid && in_ready;

      s1_vld_d  = s1_vld_q;
      s1_mag_d  = s1_mag_q;
      s1_sign_d = s1_sign_q;
      s1_ovf_d  = s1_ovf_q;
      out_vld_d = out_vld_q;
      r_d       = r_q;
      ovf_d     = ovf_q;
      zero_d    = zero_q;
      acc_d     = acc_q;

      if (advance) begin
         s1_vld_d  = fire;
         out_vld_d = s1_vld_q;

         // Data registers load only with a real beat so the outputs stay
         // quiet across bubbles.
         if (fire) begin
            s1_mag_d  = res_mag;
            s1_sign_d = res_sign;
            s1_ovf_d  = res_ovf;
         end

         if (s1_vld_q) begin
            r_d    = {s1_sign_q & (|s1_mag_q), s1_mag_q};
            ovf_d  = s1_ovf_q;
            zero_d = ~(|s1_mag_q);
         end
      end

      // The accumulator moves at the acceptance edge so the next op,
      // possibly in the very next cycle, already sees the updated value.
      if (acc_clr) begin
         acc_d = '0;
      end
      if (fire && is_acc) begin
         acc_d = {res_sign, res_mag};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q  <= 1'b0;
         s1_mag_q  <= '0;
         s1_sign_q <= 1'b0;
         s1_ovf_q  <= 1'b0;
         out_vld_q <= 1'b0;
         r_q       <= '0;
         ovf_q     <= 1'b0;
         zero_q    <= 1'b0;
         acc_q     <= '0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_mag_q  <= s1_mag_d;
         s1_sign_q <= s1_sign_d;
         s1_ovf_q  <= s1_ovf_d;
         out_vld_q <= out_vld_d;
         r_q       <= r_d;
         ovf_q     <= ovf_d;
         zero_q    <= zero_d;
         acc_q     <= acc_d;
      end
   end

   assign out_valid = out_vld_q;
   assign r         = r_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Directed bench for sm_addsub_pipe (W=3): vector table plus hand-written
// sequences for back-to-back accumulate, backpressure and mid-flight reset.

module tb_sm_addsub_pipe;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] op;
   logic [2:0] a;
   logic [2:0] b;
   logic       acc_clr;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] r;
   logic       ovf;
   logic       zero;
   logic [3:0] acc_q;

   sm_addsub_pipe #(.W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .acc_clr   (acc_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .r         (r),
      .ovf       (ovf),
      .zero      (zero),
      .acc_q     (acc_q)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] op;
      logic [2:0] a;
      logic [2:0] b;
      logic       clr;
      logic [3:0] r;
      logic       ovf;
      logic       zero;
      logic [3:0] acc;
   } vec_t;

   vec_t vecs [21];

   int n_cmp = 0;
   int n_bad = 0;

   // Output beats as {r, ovf, zero}; a beat counts when out_valid & out_ready
   // hold through the coming rising edge and reset is not asserted.
   logic [5:0] q [$];

   always @(negedge clk) begin
      #1;
      if (!rst && out_valid && out_ready) q.push_back({r, ovf, zero});
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   logic [2:0] bp_a [4];
   logic [2:0] bp_b [4];
   logic [5:0] bp_exp [4];
   logic [5:0] acc_exp [4];
   int         idx;
   logic       rdy;

   initial begin
      //          op     a       b       clr   r        ovf   zero  acc
      vecs[0]  = '{2'b00, 3'b011, 3'b110, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000};
      vecs[1]  = '{2'b01, 3'b101, 3'b001, 1'b0, 4'b1010, 1'b0, 1'b0, 4'b0000};
      vecs[2]  = '{2'b01, 3'b001, 3'b001, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000};
      vecs[3]  = '{2'b00, 3'b100, 3'b000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000};
      vecs[4]  = '{2'b00, 3'b001, 3'b001, 1'b1, 4'b0010, 1'b0, 1'b0, 4'b0000};
      vecs[5]  = '{2'b10, 3'b011, 3'b000, 1'b0, 4'b0011, 1'b0, 1'b0, 4'b0011};
      vecs[6]  = '{2'b10, 3'b011, 3'b000, 1'b0, 4'b0110, 1'b0, 1'b0, 4'b0110};
      vecs[7]  = '{2'b10, 3'b011, 3'b000, 1'b0, 4'b0111, 1'b1, 1'b0, 4'b0111};
      vecs[8]  = '{2'b11, 3'b011, 3'b000, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100};
      vecs[9]  = '{2'b10, 3'b001, 3'b000, 1'b0, 4'b0101, 1'b0, 1'b0, 4'b0101};
      vecs[10] = '{2'b10, 3'b111, 3'b000, 1'b1, 4'b1011, 1'b0, 1'b0, 4'b1011};
      vecs[11] = '{2'b10, 3'b111, 3'b000, 1'b0, 4'b1110, 1'b0, 1'b0, 4'b1110};
      vecs[12] = '{2'b10, 3'b111, 3'b000, 1'b0, 4'b1111, 1'b1, 1'b0, 4'b1111};
      vecs[13] = '{2'b11, 3'b111, 3'b000, 1'b0, 4'b1100, 1'b0, 1'b0, 4'b1100};
      vecs[14] = '{2'b10, 3'b011, 3'b000, 1'b0, 4'b1001, 1'b0, 1'b0, 4'b1001};
      vecs[15] = '{2'b10, 3'b001, 3'b000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000};
      vecs[16] = '{2'b10, 3'b100, 3'b000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000};
      vecs[17] = '{2'b11, 3'b000, 3'b000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000};
      vecs[18] = '{2'b00, 3'b111, 3'b111, 1'b0, 4'b1110, 1'b0, 1'b0, 4'b0000};
      vecs[19] = '{2'b01, 3'b011, 3'b111, 1'b0, 4'b0110, 1'b0, 1'b0, 4'b0000};
      vecs[20] = '{2'b11, 3'b010, 3'b000, 1'b0, 4'b1010, 1'b0, 1'b0, 4'b1010};

      bp_a[0] = 3'b001; bp_b[0] = 3'b001; bp_exp[0] = {4'b0010, 1'b0, 1'b0};
      bp_a[1] = 3'b010; bp_b[1] = 3'b001; bp_exp[1] = {4'b0011, 1'b0, 1'b0};
      bp_a[2] = 3'b011; bp_b[2] = 3'b011; bp_exp[2] = {4'b0110, 1'b0, 1'b0};
      bp_a[3] = 3'b001; bp_b[3] = 3'b000; bp_exp[3] = {4'b0001, 1'b0, 1'b0};

      acc_exp[0] = {4'b0011, 1'b0, 1'b0};
      acc_exp[1] = {4'b0110, 1'b0, 1'b0};
      acc_exp[2] = {4'b0111, 1'b1, 1'b0};
      acc_exp[3] = {4'b0100, 1'b0, 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      op        = 2'b00;
      a         = 3'b000;
      b         = 3'b000;
      acc_clr   = 1'b0;
      out_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_r", r, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_zero", zero, 0);
      chk("rst_acc", acc_q, 0);
      rst = 1'b0;

      // Table: one beat at a time, result checked after the second edge.
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         op       = vecs[i].op;
         a        = vecs[i].a;
         b        = vecs[i].b;
         acc_clr  = vecs[i].clr;
         #1;
         chk($sformatf("v%0d_in_ready", i), in_ready, 1);
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0;
         acc_clr  = 1'b0;
         @(posedge clk);
         @(negedge clk);
         #1;
         chk($sformatf("v%0d_out_valid", i), out_valid, 1);
         chk($sformatf("v%0d_r", i), r, vecs[i].r);
         chk($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
         chk($sformatf("v%0d_zero", i), zero, vecs[i].zero);
         chk($sformatf("v%0d_acc", i), acc_q, vecs[i].acc);
      end

      // acc_clr alone, then back-to-back accumulates with no bubble.
      @(negedge clk);
      q.delete();
      acc_clr = 1'b1;
      @(negedge clk);
      acc_clr = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("clr_no_beat", q.size(), 0);
      chk("clr_out_valid", out_valid, 0);
      chk("clr_acc", acc_q, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         op       = (i == 3) ? 2'b11 : 2'b10;
         a        = 3'b011;
         #1;
         chk($sformatf("b2b%0d_in_ready", i), in_ready, 1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("b2b_count", q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < q.size()) chk($sformatf("b2b%0d_beat", i), q[i], acc_exp[i]);
         else              chk($sformatf("b2b%0d_beat", i), 32'hdead, acc_exp[i]);
      end
      chk("b2b_acc", acc_q, 4'b0100);

      // Backpressure: stall 4 cycles while streaming, then release.
      @(negedge clk);
      q.delete();
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         in_valid = 1'b1;
         op       = 2'b00;
         a        = bp_a[idx];
         b        = bp_b[idx];
         #1;
         rdy = in_ready;
         if (c >= 2) chk($sformatf("bp_stable%0d", c), r, 4'b0010);
         @(posedge clk);
         if (rdy) idx++;
      end
      @(negedge clk);
      #1;
      chk("bp_accepted", idx, 2);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_r_held", r, 4'b0010);
      for (int c = 0; c < 20 && idx < 4; c++) begin
         @(negedge clk);
         out_ready = 1'b1;
         in_valid  = 1'b1;
         op        = 2'b00;
         a         = bp_a[idx];
         b         = bp_b[idx];
         #1;
         rdy = in_ready;
         @(posedge clk);
         if (rdy) idx++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk("bp_all_accepted", idx, 4);
      chk("bp_count", q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < q.size()) chk($sformatf("bp%0d_beat", i), q[i], bp_exp[i]);
         else              chk($sformatf("bp%0d_beat", i), 32'hdead, bp_exp[i]);
      end

      // Reset with both stages full.
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      op        = 2'b10;
      a         = 3'b011;
      repeat (2) @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("full_out_valid", out_valid, 1);
      chk("full_in_ready", in_ready, 0);
      q.delete();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_acc", acc_q, 0);
      chk("mid_rst_r", r, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      chk("post_rst_no_beat", q.size(), 0);
      chk("post_rst_out_valid", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
